ea_sequencer: RTL and testbench

Parametrised 6502 effective-address sequencer: takes over the bus after opcode decode, walks the operand/pointer/index cycles for all eight memory addressing modes, and hands the CPU core a final effective address (EA) plus page-cross flag. It sits between the controller FSM and the address mux and replaces the per-mode ABS/ABSX/ABSY/INDX/ZP states in the core. It adds zp,X, zp,Y and (ind),Y; stores always taking the fix-up cycle; true page-cross fix-up; and a `ready` stall.

---
 rtl/ea_sequencer_pkg.sv | 26 ++
 rtl/ea_sequencer_if.sv | 29 ++
 rtl/ea_sequencer_idx_add8.sv | 15 +
 rtl/ea_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_ea_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ea_sequencer_pkg.sv
// Shared types for the effective-address sequencer: addressing modes and
// sequencer states.
package ea_sequencer_pkg;

   typedef enum logic [2:0] {
      MODE_ZP   = 3'd0,
      MODE_ZPX  = 3'd1,
      MODE_ZPY  = 3'd2,
      MODE_ABS  = 3'd3,
      MODE_ABSX = 3'd4,
      MODE_ABSY = 3'd5,
      MODE_INDX = 3'd6,
      MODE_INDY = 3'd7
   } ea_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPH   = 3'd1,
      ST_DUMMY = 3'd2,
      ST_PTRL  = 3'd3,
      ST_PTRH  = 3'd4,
      ST_FIX   = 3'd5,
      ST_EA    = 3'd6
   } ea_state_t;

endpackage

// File: rtl/ea_sequencer_if.sv
// Core-side handshake and bus signals of the effective-address sequencer.
interface ea_sequencer_if;
   import ea_sequencer_pkg::*;

   logic        ready;
   logic        start;
   ea_mode_t    mode;
   logic        is_store;
   logic [7:0]  d_in;
   logic [7:0]  x;
   logic [7:0]  y;
   logic        busy;
   logic        bus_own;
   logic [15:0] addr;
   logic        pc_inc;
   logic        ea_valid;
   logic [15:0] ea;
   logic        page_cross;

   modport master (
      output ready, start, mode, is_store, d_in, x, y,
      input  busy, bus_own, addr, pc_inc, ea_valid, ea, page_cross
   );

   modport slave (
      input  ready, start, mode, is_store, d_in, x, y,
      output busy, bus_own, addr, pc_inc, ea_valid, ea, page_cross
   );
endinterface

// File: rtl/ea_sequencer_idx_add8.sv
// 8-bit index adder; page_o is the zero-page high byte, which either wraps
// (always 0x00) or picks up the carry.
module idx_add8 #(
   parameter bit ZP_WRAP = 1'b1
) (
   input  logic [7:0] a_i,
   input  logic [7:0] b_i,
   input  logic       carry_i,
   output logic [7:0] sum_o,
   output logic       carry_o,
   output logic [7:0] page_o
);
   assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {8'h00, carry_i};
   assign page_o           = ZP_WRAP ? 8'h00 : {7'h00, carry_o};
endmodule

// File: rtl/ea_sequencer.sv
// 6502 effective-address sequencer: walks operand/pointer/index cycles and
// presents the final EA with its page-cross flag.
//
//   state | meaning
//   IDLE  | core owns the bus; start latches mode and first operand
//   OPH   | core fetches operand high byte (ADH)
//   DUMMY | NMOS dummy read of the unindexed zero-page address
//   PTRL  | read pointer low byte from zero page
//   PTRH  | read pointer high byte from zero page
//   FIX   | page-cross / store fix-up read at the uncorrected address
//   EA    | addr == ea, ea_valid high
module ea_sequencer
   import ea_sequencer_pkg::*;
#(
   parameter bit ZP_WRAP   = 1'b1,
   parameter bit STORE_FIX = 1'b1,
   parameter bit DUMMY_RD  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   ea_sequencer_if.slave bus
);

   ea_state_t   state_q;
   ea_mode_t    mode_q;
   logic        store_q;
   logic [7:0]  op_q;
   logic [7:0]  low_q;
   logic        carry_q;
   logic [7:0]  zphi_q;
   logic [7:0]  adh_q;
   logic [7:0]  ptrl_q;
   logic [15:0] ptrh_q;
   logic [15:0] ea_q;
   logic        pcross_q;

   logic [7:0]  add_a;
   logic [7:0]  add_b;
   logic        add_cin;
   logic [7:0]  add_sum;
   logic        add_co;
   logic [7:0]  add_page;
   logic        store_fix;

   // One adder serves three purposes: op+idx at start, ptr+1 in PTRL, ptrL+Y in PTRH.
   always_comb begin
      add_a   = bus.d_in;
      add_b   = 8'h00;
      add_cin = 1'b0;
      case (state_q)
         ST_PTRL: begin
            add_a   = low_q;
            add_cin = 1'b1;
         end
         ST_PTRH: begin
            add_a = ptrl_q;
            add_b = bus.y;
         end
         default: begin
            case (bus.mode)
               MODE_ZPX, MODE_ABSX, MODE_INDX: add_b = bus.x;
               MODE_ZPY, MODE_ABSY:            add_b = bus.y;
               default:                        add_b = 8'h00;
            endcase
         end
      endcase
   end

   idx_add8 #(.ZP_WRAP(ZP_WRAP)) u_add (
      .a_i     (add_a),
      .b_i     (add_b),
      .carry_i (add_cin),
      .sum_o   (add_sum),
      .carry_o (add_co),
      .page_o  (add_page)
   );

   // Non-carry store fix-up is itself a dummy read, so it needs DUMMY_RD too.
   assign store_fix = store_q & STORE_FIX & DUMMY_RD;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         mode_q   <= MODE_ZP;
         store_q  <= 1'b0;
         op_q     <= 8'h00;
         low_q    <= 8'h00;
         carry_q  <= 1'b0;
         zphi_q   <= 8'h00;
         adh_q    <= 8'h00;
         ptrl_q   <= 8'h00;
         ptrh_q   <= 16'h0000;
         ea_q     <= 16'h0000;
         pcross_q <= 1'b0;
      end else if (bus.ready) begin
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  mode_q  <= bus.mode;
                  store_q <= bus.is_store;
                  op_q    <= bus.d_in;
                  low_q   <= add_sum;
                  carry_q <= add_co;
                  zphi_q  <= add_page;
                  case (bus.mode)
                     MODE_ZP: begin
                        state_q  <= ST_EA;
                        ea_q     <= {8'h00, bus.d_in};
                        pcross_q <= 1'b0;
                     end
                     MODE_ZPX, MODE_ZPY: begin
                        if (DUMMY_RD) begin
                           state_q <= ST_DUMMY;
                        end else begin
                           state_q  <= ST_EA;
                           ea_q     <= {add_page, add_sum};
                           pcross_q <= 1'b0;
                        end
                     end
                     MODE_INDX: state_q <= DUMMY_RD ? ST_DUMMY : ST_PTRL;
                     MODE_INDY: state_q <= ST_PTRL;
                     default:   state_q <= ST_OPH;
                  endcase
               end
            end
            ST_OPH: begin
               adh_q <= bus.d_in;
               if (mode_q == MODE_ABS) begin
                  state_q  <= ST_EA;
                  ea_q     <= {bus.d_in, op_q};
                  pcross_q <= 1'b0;
               end else if (carry_q || store_fix) begin
                  state_q <= ST_FIX;
               end else begin
                  state_q  <= ST_EA;
                  ea_q     <= {bus.d_in, low_q};
                  pcross_q <= 1'b0;
               end
            end
            ST_DUMMY: begin
               if (mode_q == MODE_INDX) begin
                  state_q <= ST_PTRL;
               end else begin
                  state_q  <= ST_EA;
                  ea_q     <= {zphi_q, low_q};
                  pcross_q <= 1'b0;
               end
            end
            ST_PTRL: begin
               ptrl_q  <= bus.d_in;
               ptrh_q  <= {zphi_q | add_page, add_sum};
               state_q <= ST_PTRH;
            end
            ST_PTRH: begin
               adh_q <= bus.d_in;
               if (mode_q == MODE_INDX) begin
                  state_q  <= ST_EA;
                  ea_q     <= {bus.d_in, ptrl_q};
                  pcross_q <= 1'b0;
               end else begin
                  low_q   <= add_sum;
                  carry_q <= add_co;
                  if (add_co || store_fix) begin
                     state_q <= ST_FIX;
                  end else begin
                     state_q  <= ST_EA;
                     ea_q     <= {bus.d_in, add_sum};
                     pcross_q <= 1'b0;
                  end
               end
            end
            ST_FIX: begin
               state_q  <= ST_EA;
               ea_q     <= {adh_q + {7'h00, carry_q}, low_q};
               pcross_q <= carry_q;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy       = (state_q != ST_IDLE);
   assign bus.bus_own    = (state_q != ST_IDLE) && (state_q != ST_OPH);
   assign bus.ea_valid   = (state_q == ST_EA);
   assign bus.pc_inc     = bus.ready &&
                           (((state_q == ST_IDLE) && bus.start) || (state_q == ST_OPH));
   assign bus.ea         = ea_q;
   assign bus.page_cross = pcross_q;

   always_comb begin
      case (state_q)
         ST_DUMMY: bus.addr = {8'h00, op_q};
         ST_PTRL:  bus.addr = {zphi_q, low_q};
         ST_PTRH:  bus.addr = ptrh_q;
         ST_FIX:   bus.addr = {adh_q, low_q};
         ST_EA:    bus.addr = ea_q;
         default:  bus.addr = 16'h0000;
      endcase
   end

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer: directed addressing-mode cases plus
// randomized sequences with ready stalls, checked against a cycle-list model.
module tb_ea_sequencer;
   import ea_sequencer_pkg::*;

   localparam bit ZP_WRAP   = 1'b1;
   localparam bit STORE_FIX = 1'b1;
   localparam bit DUMMY_RD  = 1'b1;

   typedef struct {
      bit        bown;
      bit [15:0] addr;
      bit        pinc;
      bit        eav;
      bit [7:0]  din;
   } rec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   ea_sequencer_if bus();

   ea_sequencer #(.ZP_WRAP(ZP_WRAP), .STORE_FIX(STORE_FIX), .DUMMY_RD(DUMMY_RD)) dut (
      .clk   (clk),
      .reset (rst_n),
      .bus   (bus)
   );

   logic [7:0]  mem [0:65535];
   rec_t        q[$];
   int          mdl_ea;
   int          mdl_pc;
   logic [7:0]  cur_op2;
   logic [15:0] prev_ea = 16'h0000;
   logic        prev_pc = 1'b0;

   logic        chk_en = 1'b0;
   logic        e_busy, e_bown, e_pinc, e_eav, e_pc;
   logic [15:0] e_addr, e_ea;
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp_v, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy",       32'(bus.busy),       32'(e_busy));
         chk("bus_own",    32'(bus.bus_own),    32'(e_bown));
         if (e_bown) chk("addr", 32'(bus.addr), 32'(e_addr));
         chk("pc_inc",     32'(bus.pc_inc),     32'(e_pinc));
         chk("ea_valid",   32'(bus.ea_valid),   32'(e_eav));
         chk("ea",         32'(bus.ea),         32'(e_ea));
         chk("page_cross", 32'(bus.page_cross), 32'(e_pc));
      end
   end

   function automatic int zpa(input int v);
      return ZP_WRAP ? (v & 255) : v;
   endfunction

   task automatic push(input bit b, input int a, input bit pi, input bit ev);
      rec_t r;
      r.bown = b;
      r.addr = a[15:0];
      r.pinc = pi;
      r.eav  = ev;
      r.din  = pi ? cur_op2 : mem[a[15:0]];
      q.push_back(r);
   endtask

   // Expected bus cycles after the start cycle, from the addressing-mode rules.
   task automatic build(input int m, input bit st, input int op1, input int op2,
                        input int xv, input int yv);
      int idx, s, p, p2, lo, hi, carry;
      q.delete();
      cur_op2 = op2[7:0];
      mdl_pc  = 0;
      case (m)
         0: mdl_ea = op1;
         1, 2: begin
            idx = (m == 1) ? xv : yv;
            if (DUMMY_RD) push(1, op1, 0, 0);
            mdl_ea = zpa(op1 + idx);
         end
         3: begin
            push(0, 0, 1, 0);
            mdl_ea = op2 * 256 + op1;
         end
         4, 5: begin
            idx   = (m == 4) ? xv : yv;
            s     = op1 + idx;
            carry = s / 256;
            push(0, 0, 1, 0);
            if (carry != 0 || (st && STORE_FIX && DUMMY_RD)) push(1, op2 * 256 + (s % 256), 0, 0);
            mdl_ea = (op2 * 256 + op1 + idx) % 65536;
            mdl_pc = carry;
         end
         6: begin
            if (DUMMY_RD) push(1, op1, 0, 0);
            p  = zpa(op1 + xv);
            p2 = zpa(op1 + xv + 1);
            push(1, p, 0, 0);
            push(1, p2, 0, 0);
            mdl_ea = int'(mem[p2]) * 256 + int'(mem[p]);
         end
         default: begin
            p  = op1;
            p2 = zpa(op1 + 1);
            push(1, p, 0, 0);
            push(1, p2, 0, 0);
            lo    = int'(mem[p]);
            hi    = int'(mem[p2]);
            carry = (lo + yv) / 256;
            if (carry != 0 || (st && STORE_FIX && DUMMY_RD)) push(1, hi * 256 + ((lo + yv) % 256), 0, 0);
            mdl_ea = (hi * 256 + lo + yv) % 65536;
            mdl_pc = carry;
         end
      endcase
      push(1, mdl_ea, 0, 1);
   endtask

   task automatic set_exp(input logic b, input logic bo, input logic [15:0] a, input logic pi,
                          input logic ev, input logic [15:0] e, input logic pc);
      e_busy = b; e_bown = bo; e_addr = a; e_pinc = pi; e_eav = ev; e_ea = e; e_pc = pc;
   endtask

   // Runs one sequence; entered and left just after a rising edge.
   task automatic txn(input int m, input bit st, input int op1, input int op2,
                      input int xv, input int yv, input int stall_at, input int stall_n,
                      input bit rnd, output int lat, output logic [15:0] ea_o, output logic pc_o);
      int  i, cyc, stalls;
      bit  rdy;
      build(m, st, op1, op2, xv, yv);
      bus.start = 1'b1; bus.mode = ea_mode_t'(3'(m)); bus.is_store = st;
      bus.x = 8'(xv); bus.y = 8'(yv); bus.ready = 1'b1; bus.d_in = 8'(op1);
      set_exp(0, 0, 16'h0000, 1, 0, prev_ea, prev_pc);
      chk_en = 1'b1;
      @(posedge clk); #1;
      i = 0; cyc = 1; stalls = 0; lat = -1;
      while (i < q.size() && cyc < 64) begin
         rdy = 1'b1;
         if (i == stall_at && stalls < stall_n) begin
            rdy = 1'b0;
            stalls++;
         end else if (rnd && $urandom_range(3) == 0) begin
            rdy = 1'b0;
         end
         bus.ready    = rdy;
         bus.start    = 1'($urandom_range(1));
         bus.mode     = ea_mode_t'(3'($urandom_range(7)));
         bus.is_store = 1'($urandom_range(1));
         bus.d_in     = q[i].din;
         set_exp(1, q[i].bown, q[i].addr, q[i].pinc & rdy, q[i].eav,
                 q[i].eav ? mdl_ea[15:0] : prev_ea, q[i].eav ? 1'(mdl_pc) : prev_pc);
         @(negedge clk); #1;
         if (bus.ea_valid && lat < 0) lat = cyc;
         @(posedge clk); #1;
         if (rdy) i++;
         cyc++;
      end
      if (i < q.size()) begin
         n_tests++; n_fail++;
         $display("FAIL seq_timeout: reached step %0d, required %0d", i, q.size());
      end
      prev_ea = mdl_ea[15:0];
      prev_pc = 1'(mdl_pc);
      ea_o = bus.ea;
      pc_o = bus.page_cross;
      // Idle cycle; a start presented with ready low must be lost.
      bus.start = 1'($urandom_range(1));
      bus.ready = bus.start ? 1'b0 : 1'($urandom_range(1));
      bus.d_in  = 8'($urandom_range(255));
      set_exp(0, 0, 16'h0000, 0, 0, prev_ea, prev_pc);
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [15:0] ea_o;
      logic        pc_o;
      int          m, op1;

      for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom_range(255));
      bus.ready = 1'b0; bus.start = 1'b0; bus.mode = MODE_ZP; bus.is_store = 1'b0;
      bus.d_in = 8'h00; bus.x = 8'h00; bus.y = 8'h00;

      #2 rst_n = 1'b0;
      #1;
      chk("rst_busy",     32'(bus.busy),       32'd0);
      chk("rst_bus_own",  32'(bus.bus_own),    32'd0);
      chk("rst_addr",     32'(bus.addr),       32'h0);
      chk("rst_pc_inc",   32'(bus.pc_inc),     32'd0);
      chk("rst_ea_valid", 32'(bus.ea_valid),   32'd0);
      chk("rst_ea",       32'(bus.ea),         32'h0);
      chk("rst_pcross",   32'(bus.page_cross), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      txn(1, 0, 8'hF0, 0, 8'h20, 0, -1, 0, 0, lat, ea_o, pc_o);
      chk("zpx_lat", 32'(lat), 32'd2);
      chk("zpx_ea", 32'(ea_o), 32'h0010);
      chk("zpx_pc", 32'(pc_o), 32'd0);

      txn(4, 0, 8'h80, 8'h12, 8'h90, 0, -1, 0, 0, lat, ea_o, pc_o);
      chk("absx_c_lat", 32'(lat), 32'd3);
      chk("absx_c_ea", 32'(ea_o), 32'h1310);
      chk("absx_c_pc", 32'(pc_o), 32'd1);

      txn(4, 0, 8'h80, 8'h12, 8'h10, 0, -1, 0, 0, lat, ea_o, pc_o);
      chk("absx_nc_lat", 32'(lat), 32'd2);
      chk("absx_nc_ea", 32'(ea_o), 32'h1290);

      txn(5, 1, 8'h00, 8'h20, 0, 8'h05, -1, 0, 0, lat, ea_o, pc_o);
      chk("absy_st_lat", 32'(lat), 32'd3);
      chk("absy_st_ea", 32'(ea_o), 32'h2005);
      chk("absy_st_pc", 32'(pc_o), 32'd0);

      mem[16'h00FF] = 8'h34; mem[16'h0000] = 8'h12;
      txn(7, 0, 8'hFF, 0, 0, 8'h01, -1, 0, 0, lat, ea_o, pc_o);
      chk("indy_lat", 32'(lat), 32'd3);
      chk("indy_ea", 32'(ea_o), 32'h1235);

      mem[16'h0015] = 8'hCD; mem[16'h0016] = 8'hAB;
      txn(6, 0, 8'h10, 0, 8'h05, 0, 2, 3, 0, lat, ea_o, pc_o);
      chk("indx_stall_lat", 32'(lat), 32'd7);
      chk("indx_stall_ea", 32'(ea_o), 32'hABCD);

      // Reset asserted while ABSX sits in OPH.
      chk_en = 1'b0;
      bus.start = 1'b1; bus.mode = MODE_ABSX; bus.is_store = 1'b0;
      bus.x = 8'h90; bus.ready = 1'b1; bus.d_in = 8'h80;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.d_in = 8'h12;
      chk("oph_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy",     32'(bus.busy),       32'd0);
      chk("mid_rst_bus_own",  32'(bus.bus_own),    32'd0);
      chk("mid_rst_addr",     32'(bus.addr),       32'h0);
      chk("mid_rst_pc_inc",   32'(bus.pc_inc),     32'd0);
      chk("mid_rst_ea",       32'(bus.ea),         32'h0);
      chk("mid_rst_pcross",   32'(bus.page_cross), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      prev_ea = 16'h0000; prev_pc = 1'b0;
      @(posedge clk); #1;

      txn(0, 0, 8'h42, 0, 0, 0, -1, 0, 0, lat, ea_o, pc_o);
      chk("zp_lat", 32'(lat), 32'd1);
      chk("zp_ea", 32'(ea_o), 32'h0042);

      for (int n = 0; n < 200; n++) begin
         m   = int'($urandom_range(7));
         op1 = ($urandom_range(3) == 0) ? 255 : int'($urandom_range(255));
         txn(m, 1'($urandom_range(1)), op1, int'($urandom_range(255)),
             int'($urandom_range(255)), int'($urandom_range(255)), -1, 0, 1, lat, ea_o, pc_o);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
